prog_delay_line: RTL and testbench
==================================

Name: prog_delay_line

Overview:
Multi-channel, run-time programmable delay line. It generalises fixed and parameter-driven delay control (#const, #param, #((d+e)/2), #reg) into synthesizable hardware. Each channel delays a valid-qualified data stream by a programmable number of clock cycles. The delay is set either directly or as the floor average of two operands. The block sits between stimulus/timing generators and downstream consumers that need cycle-exact skew alignment.

Parameters:
WIDTH, 32, data width per channel.
CHANNELS, 2, number of independent delay channels (>=1).
MAX_DELAY, 15, maximum delay in cycles (>=1); each channel has this many pipeline stages.
DEFAULT_DELAY, 10, delay loaded into every channel at reset (1..MAX_DELAY).
DW, $clog2(MAX_DELAY+1), width of delay operands (derived, localparam-style).
CW, (CHANNELS>1 ? $clog2(CHANNELS) : 1), channel-select width (derived).

Ports:
clk  input  1  clock.
rst  input  1  reset: asynchronous and active-high.
cfg_valid  input  1  configuration request.
cfg_ready  output  1  the selected channel accepts configuration.
cfg_chan  input  CW  target channel of the configuration.
cfg_avg  input  1  0: delay = cfg_delay_a; 1: delay = floor((cfg_delay_a+cfg_delay_b)/2).
cfg_delay_a  input  DW  delay operand A.
cfg_delay_b  input  DW  delay operand B (used only when cfg_avg=1).
in_valid  input  CHANNELS  per-channel input qualifier.
in_data  input  CHANNELS*WIDTH  per-channel input data; channel i occupies bits [i*WIDTH +: WIDTH].
out_valid  output  CHANNELS  per-channel delayed qualifier.
out_data  output  CHANNELS*WIDTH  per-channel delayed data.
delay_cur  output  CHANNELS*DW  active delay of each channel.
drop_cnt  output  CHANNELS*8  per-channel saturating count of inputs dropped during flush.

Behaviour:
- Reset, asynchronous:
  - all stage valid bits = 0; out_valid = 0; out_data = 0.
  - delay_cur = DEFAULT_DELAY for every channel; drop_cnt = 0; every channel FSM = ACTIVE.
- Per-channel pipeline: MAX_DELAY stages, each holding {valid, data}. Every clock, stage[0] <= {in_valid[i], in_data[i]} and stage[k] <= stage[k-1]. Bubbles propagate; there is no backpressure.
- Output tap:
  - out_valid[i]/out_data[i] = stage[delay_cur[i]-1], registered.
  - A sample presented at edge t appears at edge t+D, so latency is exactly D cycles.
  - out_data holds its last value while out_valid = 0 (no zeroing).
- Delay computation:
  - The sum a+b is formed at DW+1 bits; the average is the floor, so no overflow.
  - The result is clamped: 0 -> 1, >MAX_DELAY -> MAX_DELAY.
- Per-channel FSM, states ACTIVE and FLUSH:
  - ACTIVE: cfg_ready = 1 when cfg_chan selects this channel. A handshake (cfg_valid & cfg_ready) loads delay_cur with the computed value and moves the channel to FLUSH.
  - FLUSH: lasts exactly 1 cycle. All stage valid bits of the channel are cleared and out_valid[i] = 0. If in_valid[i] = 1 that cycle, the sample is dropped and drop_cnt[i] increments, saturating at 255. The channel then returns to ACTIVE.
  - After FLUSH, the first new sample appears exactly new-D cycles after entry.
- cfg_ready = (state of channel cfg_chan == ACTIVE). If cfg_chan >= CHANNELS, cfg_ready = 0 and the request is ignored.
- Other channels are unaffected by a configuration of channel i, including a configuration in the same cycle.
- Simultaneous events:
  - An input on the handshake cycle enters the old pipeline and is then flushed. It is not counted as dropped; only FLUSH-cycle inputs are counted.
  - A configuration of a channel already in FLUSH is back-pressured (cfg_ready = 0).
- Reset mid-operation discards all in-flight samples immediately (asynchronous) and restores DEFAULT_DELAY.

Test Plan:
- Reset, then in_valid[0]=1 with data 0xA5 at cycle 0 -> out_valid[0]=1 with 0xA5 at cycle 10 only; delay_cur[0]=10; other outputs 0.
- cfg ch1, cfg_avg=1, a=3, b=8 -> delay_cur[1]=5 (floor of 5.5); 8-sample burst 1..8 -> outputs 1..8 exactly 5 cycles later, gap-free; ch0 timing unchanged.
- cfg a=0 -> delay 1; cfg a=15, b=15, avg -> delay 15; MAX_DELAY=15 build with a=15 on 4-bit operands, sum 30 -> no overflow, delay 15.
- Stream continuously on ch0, reconfigure to delay 3 mid-stream -> in-flight samples never emerge; FLUSH-cycle input dropped and drop_cnt[0]=1; the next sample emerges 3 cycles later; 300 reconfigurations with input high -> drop_cnt saturates at 255.
- Back-to-back cfg_valid on the same channel -> cfg_ready=0 on the FLUSH cycle and the second config is accepted one cycle later; cfg_chan=2 with CHANNELS=2 -> cfg_ready=0, no state change.
- Assert rst asynchronously mid-burst (between edges) -> out_valid drops immediately; delay_cur returns to 10; after release, no stale samples appear.

Source files
------------

// File: rtl/prog_delay_line.sv
// ============================================================================
//  Module   : prog_delay_line
//  Purpose  : Multi-channel delay line. Each channel has its own run-time
//             programmable latency, set directly or as the floor average of
//             two operands.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_delay_line #(
    parameter int WIDTH         = 32,
    parameter int CHANNELS      = 2,
    parameter int MAX_DELAY     = 15,
    parameter int DEFAULT_DELAY = 10,
    localparam int DW           = $clog2(MAX_DELAY + 1),
    localparam int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [CW-1:0]             cfg_chan,
    input  logic                      cfg_avg,
    input  logic [DW-1:0]             cfg_delay_a,
    input  logic [DW-1:0]             cfg_delay_b,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS*DW-1:0]    delay_cur,
    output logic [CHANNELS*8-1:0]     drop_cnt
);

    typedef enum logic [0:0] {
        ACTIVE = 1'b0,
        FLUSH  = 1'b1
    } chan_state_t;

    logic [DW:0]         op_sum;
    logic [DW:0]         op_pick;
    logic [DW-1:0]       new_delay;
    logic [CHANNELS-1:0] chan_active;

    // Sum is one bit wider than the operands, so the average cannot overflow.
    always_comb begin
        op_sum  = {1'b0, cfg_delay_a} + {1'b0, cfg_delay_b};
        op_pick = cfg_avg ? (op_sum >> 1) : {1'b0, cfg_delay_a};
        if (op_pick == '0) begin
            new_delay = DW'(1);
        end else if (op_pick > (DW + 1)'(MAX_DELAY)) begin
            new_delay = DW'(MAX_DELAY);
        end else begin
            new_delay = op_pick[DW-1:0];
        end
    end

    // Out-of-range channel codes match no channel and therefore never see ready.
    always_comb begin
        cfg_ready = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if ((cfg_chan == CW'(c)) && chan_active[c]) begin
                cfg_ready = 1'b1;
            end
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        chan_state_t          state;
        chan_state_t          state_next;
        logic                 take;
        logic                 flushing;
        logic [MAX_DELAY-1:0] stg_valid;
        logic [WIDTH-1:0]     stg_data [MAX_DELAY];
        logic                 tap_valid;
        logic [WIDTH-1:0]     tap_data;
        logic                 dly_valid;
        logic [WIDTH-1:0]     dly_data;
        logic [DW-1:0]        dly;
        logic [7:0]           drops;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= ACTIVE;
            end else begin
                state <= state_next;
            end
        end

        always_comb begin
            state_next = state;
            take       = 1'b0;
            flushing   = 1'b0;
            case (state)
                ACTIVE: begin
                    if (cfg_valid && (cfg_chan == CW'(ch))) begin
                        take       = 1'b1;
                        state_next = FLUSH;
                    end
                end
                FLUSH: begin
                    flushing   = 1'b1;
                    state_next = ACTIVE;
                end
                default: state_next = ACTIVE;
            endcase
        end

        assign chan_active[ch] = (state == ACTIVE);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stg_valid <= '0;
            end else begin
                stg_valid[0] <= ~flushing & in_valid[ch];
                for (int k = 1; k < MAX_DELAY; k++) begin
                    stg_valid[k] <= ~flushing & stg_valid[k-1];
                end
            end
        end

        // Payload needs no reset: it is only ever observed behind a valid bit.
        always_ff @(posedge clk) begin
            stg_data[0] <= in_data[ch*WIDTH +: WIDTH];
            for (int k = 1; k < MAX_DELAY; k++) begin
                stg_data[k] <= stg_data[k-1];
            end
        end

        always_comb begin
            tap_valid = 1'b0;
            tap_data  = '0;
            for (int k = 0; k < MAX_DELAY; k++) begin
                if (dly == DW'(k + 1)) begin
                    tap_valid = stg_valid[k];
                    tap_data  = stg_data[k];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dly_valid <= 1'b0;
                dly_data  <= '0;
            end else if (flushing) begin
                dly_valid <= 1'b0;
            end else begin
                dly_valid <= tap_valid;
                if (tap_valid) begin
                    dly_data <= tap_data;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dly <= DW'(DEFAULT_DELAY);
            end else if (take) begin
                dly <= new_delay;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                drops <= '0;
            end else if (flushing && in_valid[ch] && (drops != 8'hFF)) begin
                drops <= drops + 8'd1;
            end
        end

        assign out_valid[ch]                 = dly_valid;
        assign out_data[ch*WIDTH +: WIDTH]   = dly_data;
        assign delay_cur[ch*DW +: DW]        = dly;
        assign drop_cnt[ch*8 +: 8]           = drops;
    end

endmodule

`default_nettype wire

// File: tb/tb_prog_delay_line.sv
// ============================================================================
//  Module   : tb_prog_delay_line
//  Purpose  : Self-checking bench for prog_delay_line (3 channels, so the
//             2-bit channel select has one out-of-range code).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_delay_line;

    localparam int WIDTH = 32;
    localparam int CH    = 3;
    localparam int MAXD  = 15;
    localparam int DEFD  = 10;
    localparam int DW    = 4;
    localparam int CW    = 2;
    localparam int N     = 1024;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cfg_valid = 1'b0;
    logic                   cfg_ready;
    logic [CW-1:0]          cfg_chan = '0;
    logic                   cfg_avg = 1'b0;
    logic [DW-1:0]          cfg_delay_a = '0;
    logic [DW-1:0]          cfg_delay_b = '0;
    logic [CH-1:0]          in_valid = '0;
    logic [CH*WIDTH-1:0]    in_data = '0;
    logic [CH-1:0]          out_valid;
    logic [CH*WIDTH-1:0]    out_data;
    logic [CH*DW-1:0]       delay_cur;
    logic [CH*8-1:0]        drop_cnt;

    always #5 clk = ~clk;

    prog_delay_line #(
        .WIDTH(WIDTH), .CHANNELS(CH), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD)
    ) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_avg(cfg_avg), .cfg_delay_a(cfg_delay_a),
        .cfg_delay_b(cfg_delay_b), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .delay_cur(delay_cur),
        .drop_cnt(drop_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted sample is booked for the cycle it must
    // emerge; a reconfiguration cancels every booking still in the future.
    bit               sv [CH][N];
    logic [WIDTH-1:0] sd [CH][N];
    int               mdly [CH];
    bit               mflush [CH];
    int               mdrop [CH];
    bit               ev [CH];
    logic [WIDTH-1:0] ed [CH];
    int               e = 0;

    function automatic int model_delay(input bit avg, input int a, input int b);
        int s;
        s = avg ? (a + b) / 2 : a;
        if (s < 1) s = 1;
        if (s > MAXD) s = MAXD;
        return s;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < N; k++) sv[c][k] = 1'b0;
            mdly[c] = DEFD; mflush[c] = 1'b0; mdrop[c] = 0;
            ev[c] = 1'b0; ed[c] = '0;
        end
    endtask

    initial model_reset();
    always @(posedge rst) model_reset();

    always @(posedge clk) begin
        e++;
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < CH; c++) begin
                ev[c] = sv[c][e % N];
                if (ev[c]) ed[c] = sd[c][e % N];
                sv[c][e % N] = 1'b0;
                if (mflush[c]) begin
                    if (in_valid[c] && mdrop[c] < 255) mdrop[c]++;
                    mflush[c] = 1'b0;
                end else if (cfg_valid && int'(cfg_chan) == c) begin
                    for (int k = 1; k <= MAXD; k++) sv[c][(e + k) % N] = 1'b0;
                    mdly[c]   = model_delay(cfg_avg, int'(cfg_delay_a), int'(cfg_delay_b));
                    mflush[c] = 1'b1;
                end else if (in_valid[c]) begin
                    sv[c][(e + mdly[c]) % N] = 1'b1;
                    sd[c][(e + mdly[c]) % N] = in_data[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    always @(posedge clk) begin
        bit er;
        #1;
        if (!rst) begin
            for (int c = 0; c < CH; c++) begin
                chk($sformatf("out_valid[%0d]", c), 64'(out_valid[c]), 64'(ev[c]));
                chk($sformatf("out_data[%0d]", c), 64'(out_data[c*WIDTH +: WIDTH]), 64'(ed[c]));
                chk($sformatf("delay_cur[%0d]", c), 64'(delay_cur[c*DW +: DW]), 64'(mdly[c]));
                chk($sformatf("drop_cnt[%0d]", c), 64'(drop_cnt[c*8 +: 8]), 64'(mdrop[c]));
            end
            er = 1'b0;
            if (int'(cfg_chan) < CH) er = !mflush[cfg_chan];
            chk("cfg_ready", 64'(cfg_ready), 64'(er));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input int c, input bit v, input logic [WIDTH-1:0] d);
        in_valid[c] = v;
        in_data[c*WIDTH +: WIDTH] = d;
    endtask

    task automatic configure(input int c, input bit avg, input int a, input int b);
        cfg_chan = CW'(c); cfg_avg = avg;
        cfg_delay_a = DW'(a); cfg_delay_b = DW'(b);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("reset out_valid", 64'(out_valid), 64'h0);
        chk("reset out_data", 64'(out_data[63:0]), 64'h0);
        chk("reset delay_cur", 64'(delay_cur), 64'hAAA);
        chk("reset drop_cnt", 64'(drop_cnt), 64'h0);
        chk("reset cfg_ready", 64'(cfg_ready), 64'h1);

        // Single sample on ch0 at default delay 10; data must hold afterwards.
        drive(0, 1'b1, 32'hA5);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) drive(0, 1'b0, 32'hDEADBEEF);
            #1;
            if (k == 10) chk("lat10 early", 64'(out_valid[0]), 64'h0);
            if (k == 11) begin
                chk("lat10 valid", 64'(out_valid[0]), 64'h1);
                chk("lat10 data", 64'(out_data[31:0]), 64'hA5);
            end
            if (k == 12) begin
                chk("lat10 after", 64'(out_valid[0]), 64'h0);
                chk("lat10 hold", 64'(out_data[31:0]), 64'hA5);
            end
        end

        // Average config on ch1 while ch0 carries a sample in the same cycle.
        cfg_chan = 2'd1; cfg_avg = 1'b1; cfg_delay_a = 4'd3; cfg_delay_b = 4'd8;
        cfg_valid = 1'b1;
        drive(0, 1'b1, 32'h1111);
        #1 chk("ready ch1", 64'(cfg_ready), 64'h1);
        step();
        cfg_valid = 1'b0;
        drive(0, 1'b0, 32'h0);
        #1;
        chk("avg 3,8", 64'(delay_cur[7:4]), 64'd5);
        chk("ch0 delay kept", 64'(delay_cur[3:0]), 64'd10);
        chk("ready in flush", 64'(cfg_ready), 64'h0);
        step();
        for (int j = 0; j < 8; j++) begin
            drive(1, 1'b1, WIDTH'(j + 1));
            step();
        end
        #1;
        chk("burst mid valid", 64'(out_valid[1]), 64'h1);
        chk("burst mid data", 64'(out_data[63:32]), 64'd3);
        drive(1, 1'b0, 32'h0);
        repeat (5) step();
        #1;
        chk("burst last valid", 64'(out_valid[1]), 64'h1);
        chk("burst last data", 64'(out_data[63:32]), 64'd8);
        step();
        #1 chk("burst end", 64'(out_valid[1]), 64'h0);

        // Delay boundaries on ch1.
        configure(1, 1'b0, 0, 0);
        #1 chk("a=0 clamps", 64'(delay_cur[7:4]), 64'd1);
        drive(1, 1'b1, 32'h77);
        step();
        drive(1, 1'b0, 32'h0);
        #1 chk("d1 early", 64'(out_valid[1]), 64'h0);
        step();
        #1;
        chk("d1 valid", 64'(out_valid[1]), 64'h1);
        chk("d1 data", 64'(out_data[63:32]), 64'h77);
        configure(1, 1'b1, 0, 1);
        #1 chk("avg 0,1", 64'(delay_cur[7:4]), 64'd1);
        configure(1, 1'b1, 15, 14);
        #1 chk("avg 15,14", 64'(delay_cur[7:4]), 64'd14);
        configure(1, 1'b1, 15, 15);
        #1 chk("avg 15,15", 64'(delay_cur[7:4]), 64'd15);
        drive(1, 1'b1, 32'hF00D);
        step();
        drive(1, 1'b0, 32'h0);
        repeat (14) step();
        #1 chk("d15 early", 64'(out_valid[1]), 64'h0);
        step();
        #1;
        chk("d15 valid", 64'(out_valid[1]), 64'h1);
        chk("d15 data", 64'(out_data[63:32]), 64'hF00D);

        // Reconfigure ch0 to 3 in the middle of a continuous stream.
        cfg_avg = 1'b0; cfg_delay_a = 4'd3; cfg_delay_b = 4'd0; cfg_chan = 2'd0;
        for (int j = 0; j < 30; j++) begin
            drive(0, 1'b1, WIDTH'(32'h100 + j));
            cfg_valid = (j == 20);
            step();
            #1;
            if (j == 20) begin
                chk("handshake tap", 64'(out_valid[0]), 64'h1);
                chk("handshake data", 64'(out_data[31:0]), 64'h10A);
            end
            if (j == 21) begin
                chk("flush out", 64'(out_valid[0]), 64'h0);
                chk("flush drop", 64'(drop_cnt[7:0]), 64'd1);
            end
            if (j == 24) chk("new d3 early", 64'(out_valid[0]), 64'h0);
            if (j == 25) begin
                chk("new d3 valid", 64'(out_valid[0]), 64'h1);
                chk("new d3 data", 64'(out_data[31:0]), 64'h116);
            end
        end
        cfg_valid = 1'b0;
        drive(0, 1'b0, 32'h0);
        step();

        // Back-to-back requests with input high: 300 flushes saturate the counter.
        cfg_chan = 2'd0; cfg_avg = 1'b0; cfg_delay_a = 4'd3;
        cfg_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            drive(0, 1'b1, WIDTH'(i));
            step();
            #1;
            if (i == 0) chk("b2b ready flush", 64'(cfg_ready), 64'h0);
            if (i == 1) chk("b2b ready again", 64'(cfg_ready), 64'h1);
            if (i == 397) chk("drop 200", 64'(drop_cnt[7:0]), 64'd200);
        end
        chk("drop saturated", 64'(drop_cnt[7:0]), 64'd255);
        cfg_valid = 1'b0;
        drive(0, 1'b0, 32'h0);
        step();

        // Out-of-range channel select.
        cfg_chan = 2'd3; cfg_delay_a = 4'd7; cfg_valid = 1'b1;
        #1 chk("chan3 ready", 64'(cfg_ready), 64'h0);
        step();
        #1 chk("chan3 no change", 64'(delay_cur), 64'hAF3);
        cfg_valid = 1'b0;
        cfg_chan = 2'd0;
        step();

        // Asynchronous reset in the middle of a burst.
        for (int j = 0; j < 6; j++) begin
            drive(0, 1'b1, WIDTH'(32'h200 + j));
            step();
        end
        #1;
        chk("pre-reset valid", 64'(out_valid[0]), 64'h1);
        chk("pre-reset data", 64'(out_data[31:0]), 64'h202);
        #1 rst = 1'b1;
        #1;
        chk("async out_valid", 64'(out_valid), 64'h0);
        chk("async delay_cur", 64'(delay_cur), 64'hAAA);
        chk("async drop_cnt", 64'(drop_cnt), 64'h0);
        drive(0, 1'b0, 32'h0);
        step();
        rst = 1'b0;
        repeat (20) step();
        drive(0, 1'b1, 32'h3C);
        step();
        drive(0, 1'b0, 32'h0);
        repeat (12) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
